// File: rtl/ped_sched_pkg.sv
// Shared encodings for the pedestrian request scheduler: FSM states,
// crosswalk indices and the width of the seconds countdown.
package ped_sched_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_SAFE = 3'd1;
    localparam logic [2:0] WALK      = 3'd2;
    localparam logic [2:0] CLEAR     = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = IDLE,
        ST_WAIT_SAFE = WAIT_SAFE,
        ST_WALK      = WALK,
        ST_CLEAR     = CLEAR,
        ST_GAP       = GAP
    } ped_state_e;

    localparam logic CROSS_A = 1'b0;
    localparam logic CROSS_B = 1'b1;

    localparam int SEC_W = 8;

endpackage

// File: rtl/ped_debounce.sv
// Button conditioning: 2-FF synchronizer, stability filter and a one-cycle
// rising-edge pulse. With PED_DEBOUNCE_EN undefined the filter is bypassed.
module ped_debounce #(
    parameter int STABLE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef PED_DEBOUNCE_EN
    localparam int              CW     = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0]   CNT_TC = CW'(STABLE_CYC - 1);

    logic [CW-1:0] cnt;
    logic          db;

    // The debounced level flips only after STABLE_CYC consecutive samples
    // that disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            db   <= 1'b0;
            rise <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_TC) begin
                cnt  <= '0;
                db   <= sync2;
                rise <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    // sync1 is next cycle's sync2, so this pulses in step with sync2 rising.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise <= 1'b0;
        end else begin
            rise <= sync1 & ~sync2;
        end
    end
`endif

endmodule

// File: rtl/ped_request_scheduler.sv
// Pedestrian crossing scheduler: latches crosswalk requests, holds traffic in
// all-red and runs WALK/CLEAR/GAP round-robin. Optional macro: PED_DEBOUNCE_EN.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | no crossing active, waiting for a latched request
//   WAIT_SAFE | hold asserted, waiting for both streets to be red
//   WALK      | WALK lamp on for the granted crosswalk, counting down
//   CLEAR     | flashing don't-walk on the granted crosswalk, counting down
//   GAP       | vehicles released, minimum gap before the next crossing
module ped_request_scheduler
    import ped_sched_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int WALK_SEC     = 10,
    parameter int CLEAR_SEC    = 5,
    parameter int MIN_GAP_SEC  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_a,
    input  logic             btn_b,
    input  logic             safe_point,
    output logic             hold,
    output logic             walk_a,
    output logic             walk_b,
    output logic             clearing,
    output logic [SEC_W-1:0] remaining,
    output logic [1:0]       pending
);

    localparam int               PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRE_TC = PW'(TICK_DIV - 1);
    localparam logic [SEC_W-1:0] ONE    = SEC_W'(1);

    logic rise_a;
    logic rise_b;

    ped_debounce #(.STABLE_CYC(DEBOUNCE_CYC)) u_db_a (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_a),
        .rise  (rise_a)
    );

    ped_debounce #(.STABLE_CYC(DEBOUNCE_CYC)) u_db_b (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_b),
        .rise  (rise_b)
    );

    ped_state_e       state_q, state_nx;
    logic [PW-1:0]    pre_q, pre_nx;
    logic [SEC_W-1:0] rem_nx;
    logic [SEC_W-1:0] gap_q, gap_nx;
    logic             grant_q, grant_nx;
    logic             last_q, last_nx;
    logic [1:0]       pend_clr, pend_nx;
    logic             hold_nx, walk_a_nx, walk_b_nx, clearing_nx;
    logic             tick;

    assign tick = (pre_q == PRE_TC);

    always_comb begin
        state_nx = state_q;
        rem_nx   = remaining;
        gap_nx   = gap_q;
        grant_nx = grant_q;
        last_nx  = last_q;
        pend_clr = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (pending != 2'b00) begin
                    state_nx = ST_WAIT_SAFE;
                    case (pending)
                        2'b01:   grant_nx = CROSS_A;
                        2'b10:   grant_nx = CROSS_B;
                        default: grant_nx = (last_q == CROSS_A) ? CROSS_B : CROSS_A;
                    endcase
                end
            end
            ST_WAIT_SAFE: begin
                if (safe_point) begin
                    state_nx          = ST_WALK;
                    rem_nx            = SEC_W'(WALK_SEC);
                    pend_clr[grant_q] = 1'b1;
                    last_nx           = grant_q;
                end
            end
            ST_WALK, ST_CLEAR: begin
                // Losing all-red mid-crossing aborts straight to the vehicle gap.
                if (!safe_point) begin
                    state_nx = ST_GAP;
                    rem_nx   = '0;
                    gap_nx   = SEC_W'(MIN_GAP_SEC);
                end else if (tick) begin
                    if (remaining != ONE) begin
                        rem_nx = remaining - 1'b1;
                    end else if (state_q == ST_WALK) begin
                        state_nx = ST_CLEAR;
                        rem_nx   = SEC_W'(CLEAR_SEC);
                    end else begin
                        state_nx = ST_GAP;
                        rem_nx   = '0;
                        gap_nx   = SEC_W'(MIN_GAP_SEC);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_q == ONE) begin
                        state_nx = ST_IDLE;
                    end else begin
                        gap_nx = gap_q - 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        pend_nx = (pending & ~pend_clr) | {rise_b, rise_a};

        // Restart the second on every timed-state entry so each lasts full ticks.
        if (state_nx != state_q &&
            (state_nx == ST_WALK || state_nx == ST_CLEAR || state_nx == ST_GAP)) begin
            pre_nx = '0;
        end else if (tick) begin
            pre_nx = '0;
        end else begin
            pre_nx = pre_q + 1'b1;
        end

        hold_nx     = (state_nx == ST_WAIT_SAFE) || (state_nx == ST_WALK) ||
                      (state_nx == ST_CLEAR);
        walk_a_nx   = (state_nx == ST_WALK) && (grant_nx == CROSS_A);
        walk_b_nx   = (state_nx == ST_WALK) && (grant_nx == CROSS_B);
        clearing_nx = (state_nx == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            remaining <= '0;
            gap_q     <= '0;
            grant_q   <= CROSS_A;
            last_q    <= CROSS_B;
            pending   <= 2'b00;
            hold      <= 1'b0;
            walk_a    <= 1'b0;
            walk_b    <= 1'b0;
            clearing  <= 1'b0;
        end else begin
            state_q   <= state_nx;
            pre_q     <= pre_nx;
            remaining <= rem_nx;
            gap_q     <= gap_nx;
            grant_q   <= grant_nx;
            last_q    <= last_nx;
            pending   <= pend_nx;
            hold      <= hold_nx;
            walk_a    <= walk_a_nx;
            walk_b    <= walk_b_nx;
            clearing  <= clearing_nx;
        end
    end

endmodule

// File: tb/tb_ped_request_scheduler.sv
// Directed bench for ped_request_scheduler: reset vector table plus
// hand-written sequences for walk timing, bounce, fault, tie and mid-op reset.
module tb_ped_request_scheduler;

    localparam int TICK_DIV     = 4;
    localparam int DEBOUNCE_CYC = 3;
    localparam int WALK_SEC     = 3;
    localparam int CLEAR_SEC    = 2;
    localparam int MIN_GAP_SEC  = 2;
`ifdef PED_DEBOUNCE_EN
    localparam int LAT = DEBOUNCE_CYC + 3;
`else
    localparam int LAT = 3;
`endif

    logic       clk;
    logic       rst_n;
    logic       btn_a;
    logic       btn_b;
    logic       safe_point;
    logic       hold;
    logic       walk_a;
    logic       walk_b;
    logic       clearing;
    logic [7:0] remaining;
    logic [1:0] pending;

    ped_request_scheduler #(
        .TICK_DIV     (TICK_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .WALK_SEC     (WALK_SEC),
        .CLEAR_SEC    (CLEAR_SEC),
        .MIN_GAP_SEC  (MIN_GAP_SEC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_a      (btn_a),
        .btn_b      (btn_b),
        .safe_point (safe_point),
        .hold       (hold),
        .walk_a     (walk_a),
        .walk_b     (walk_b),
        .clearing   (clearing),
        .remaining  (remaining),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [13:0] obs;
    assign obs = {hold, walk_a, walk_b, clearing, remaining, pending};

    typedef struct {
        logic        rst_n;
        logic        btn_a;
        logic        btn_b;
        logic        safe;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[16];
    int   n_tbl;
    int   n_cmp;
    int   n_err;

    function automatic logic [13:0] pk(input logic h, input logic wa, input logic wb,
                                       input logic clr, input logic [7:0] rem,
                                       input logic [1:0] pd);
        return {h, wa, wb, clr, rem, pd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] got;
        got = obs;
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got hold=%b walk_a=%b walk_b=%b clr=%b rem=%0d pend=%b, want hold=%b walk_a=%b walk_b=%b clr=%b rem=%0d pend=%b",
                     name, got[13], got[12], got[11], got[10], got[9:2], got[1:0],
                     exp[13], exp[12], exp[11], exp[10], exp[9:2], exp[1:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pend_at, hold_at, wa_at, wb_at, p11_at, overlap, gap_cyc, k;
        logic [1:0] pend_wa;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        btn_a = 1'b1;
        btn_b = 1'b0;
        safe_point = 1'b0;

        // Reset with btn_a held, then release and watch the request latch.
        n_tbl = 0;
        tbl[n_tbl] = '{1'b0, 1'b1, 1'b0, 1'b0, pk(0, 0, 0, 0, 8'd0, 2'b00)}; n_tbl++;
        tbl[n_tbl] = '{1'b0, 1'b1, 1'b0, 1'b0, pk(0, 0, 0, 0, 8'd0, 2'b00)}; n_tbl++;
        for (int i = 1; i <= LAT + 1; i++) begin
            tbl[n_tbl] = '{1'b1, 1'b1, 1'b0, 1'b0,
                           pk(i >= LAT + 1, 0, 0, 0, 8'd0, (i >= LAT) ? 2'b01 : 2'b00)};
            n_tbl++;
        end
        for (int i = 0; i < n_tbl; i++) begin
            rst_n = tbl[i].rst_n;
            btn_a = tbl[i].btn_a;
            btn_b = tbl[i].btn_b;
            safe_point = tbl[i].safe;
            step();
            check($sformatf("reset_vec%0d", i), tbl[i].exp);
        end

        // Full WALK / CLEAR / GAP run for crosswalk A.
        safe_point = 1'b1;
        btn_a = 1'b0;
        step();
        for (int c = 0; c < 12; c++) begin
            check($sformatf("walk_a_c%0d", c), pk(1, 1, 0, 0, 8'(3 - c / 4), 2'b00));
            step();
        end
        for (int c = 0; c < 8; c++) begin
            check($sformatf("clear_c%0d", c), pk(1, 0, 0, 1, 8'(2 - c / 4), 2'b00));
            step();
        end
        for (int c = 0; c < 12; c++) begin
            check($sformatf("gap_idle_c%0d", c), pk(0, 0, 0, 0, 8'd0, 2'b00));
            step();
        end

        // Bouncing B button.
        safe_point = 1'b0;
        for (int c = 0; c < 18; c++) begin
            btn_b = (c < 10) ? ~btn_b : 1'b0;
            step();
`ifdef PED_DEBOUNCE_EN
            check($sformatf("bounce_c%0d", c), pk(0, 0, 0, 0, 8'd0, 2'b00));
`endif
        end
`ifndef PED_DEBOUNCE_EN
        check("bounce_bypass", pk(1, 0, 0, 0, 8'd0, 2'b10));
`endif
        rst_n = 1'b0;
        step();
        step();
        check("bounce_reset", pk(0, 0, 0, 0, 8'd0, 2'b00));
        rst_n = 1'b1;

        // Five-cycle A pulse: request and hold latency.
        btn_a = 1'b1;
        pend_at = -1;
        hold_at = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 5) btn_a = 1'b0;
            if (pend_at < 0 && pending != 2'b00) pend_at = i;
            if (hold_at < 0 && hold) hold_at = i;
        end
        check_int("pulse_pend_latency", pend_at, LAT);
        check_int("pulse_hold_latency", hold_at, LAT + 1);

        // Fault: safe_point drops during WALK at remaining=2.
        safe_point = 1'b1;
        step();
        check("fault_walk_entry", pk(1, 1, 0, 0, 8'd3, 2'b00));
        for (int i = 0; i < 4; i++) step();
        check("fault_rem2", pk(1, 1, 0, 0, 8'd2, 2'b00));
        safe_point = 1'b0;
        step();
        check("fault_abort", pk(0, 0, 0, 0, 8'd0, 2'b00));
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("fault_gap_c%0d", c), pk(0, 0, 0, 0, 8'd0, 2'b00));
        end

        // Tie after reset: A first, B after the gap, never both lamps.
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        btn_a = 1'b1;
        btn_b = 1'b1;
        safe_point = 1'b1;
        k = 0;
        wa_at = -1;
        wb_at = -1;
        p11_at = -1;
        overlap = 0;
        gap_cyc = 0;
        pend_wa = 2'b00;
        while (wb_at < 0 && k < 80) begin
            step();
            k++;
            if (walk_a && walk_b) overlap++;
            if (p11_at < 0 && pending == 2'b11) p11_at = k;
            if (wa_at < 0 && walk_a) begin
                wa_at = k;
                pend_wa = pending;
            end
            if (wa_at >= 0 && !hold) gap_cyc++;
            if (walk_b) wb_at = k;
        end
        check_int("tie_both_pending", p11_at, LAT);
        check_int("tie_walk_a_first", wa_at, LAT + 2);
        check_int("tie_pending_after_a", int'(pend_wa), 2);
        check_int("tie_gap_cycles", gap_cyc, 9);
        check_int("tie_walk_b_offset", wb_at - wa_at, 30);
        check_int("tie_lamp_overlap", overlap, 0);

        // Re-request of B during its own WALK, then reset mid-CLEAR.
        btn_a = 1'b0;
        btn_b = 1'b0;
        for (int i = 0; i < 6; i++) step();
        btn_b = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("rereq_in_clear", pk(1, 0, 0, 1, 8'd1, 2'b10));
        rst_n = 1'b0;
        btn_b = 1'b0;
        step();
        check("midop_reset", pk(0, 0, 0, 0, 8'd0, 2'b00));
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("post_reset_c%0d", c), pk(0, 0, 0, 0, 8'd0, 2'b00));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
